wfg_core_seq: RTL and testbench
===============================

# wfg_core_seq

Parametrised successor to the waveform-generator core timing engine. Generates nested subcycle/sync timing, with four additions: configurable counter widths, NCH per-channel phase strobes, a burst mode that runs a fixed number of sync periods and then halts, and shadowed thresholds so that reconfiguring mid-run never produces a torn period. Sits between the core register block and the pattern/driver blocks, which consume its strobes.

## Interface
- SUBW, default 16: subcycle threshold width.
- SYNCW, default 8: sync threshold and subcycle-index width.
- BURSTW, default 8: burst length width.
- NCH, default 4: number of phase-strobe channels (1..16).
- wb_clk_i, in, 1: clock.
- wb_rst_i, in, 1: reset. Synchronous and active-high.
- en_i, in, 1: enable (level).
- mode_i, in, 1: 0 = continuous, 1 = burst.
- subcycle_cnt_i, in, SUBW: subcycle length is subcycle_cnt_i+1 clocks.
- sync_cnt_i, in, SYNCW: sync period is sync_cnt_i+1 subcycles.
- burst_len_i, in, BURSTW: number of sync periods per burst; 0 is treated as 1.
- ch_phase_i, in, NCH*SYNCW: channel c phase, in slice [c*SYNCW +: SYNCW].
- wfg_pat_sync_o, out, 1: sync-period start strobe.
- wfg_pat_subcycle_o, out, 1: subcycle start strobe.
- wfg_pat_start_o, out, 1: run start strobe.
- wfg_pat_subcycle_cnt_o, out, SYNCW: index of the current subcycle within the sync period.
- ch_strobe_o, out, NCH: per-channel phase strobes.
- done_o, out, 1: burst-complete strobe.
- active_o, out, 1: running indication.

## Operation
- FSM states: IDLE, RUN, HOLD. Reset enters IDLE; every output is 0 and all counters are 0.
- IDLE → RUN when en_i=1. On this transition:
  - latch subcycle_cnt_i, sync_cnt_i and burst_len_i into shadow registers;
  - clear the subcycle counter sc, the subcycle index si and the burst counter bc.
- In RUN, sc counts 0..shadow_sub.
  - When sc wraps, si increments.
  - When si wraps past shadow_sync, bc increments and the shadows reload from the inputs. Reconfiguration therefore takes effect only at a sync boundary.
- Registered strobes. Each is a 1-cycle pulse in the first cycle of its interval:
  - wfg_pat_subcycle_o: when sc==0.
  - wfg_pat_sync_o: when sc==0 and si==0.
  - wfg_pat_start_o: first RUN cycle only.
  - ch_strobe_o[c]: when sc==0 and si==ch_phase_i[c]. Phases are sampled live. A phase greater than shadow_sync never fires.
- wfg_pat_subcycle_cnt_o = si during RUN, 0 otherwise. active_o = 1 exactly during RUN.
- Burst mode: after the final clock of period number max(burst_len,1), go RUN → HOLD.
  - done_o pulses 1 cycle, in the first HOLD cycle.
  - Stay in HOLD until en_i=0, then go to IDLE. There is no re-trigger while en_i stays high.
- Continuous mode: run until en_i=0. mode_i is sampled only at IDLE→RUN.
- en_i=0 in RUN or HOLD: go to IDLE on the next edge. Counters clear; no done_o and no sync strobe is issued.
- Reset mid-run: same as the reset state on the next edge. Reset overrides en_i.
- Simultaneous events: the burst-final period end coincides with en_i=0 → en_i wins; go to IDLE with no done_o.

## Timing
- en_i sampled high at edge k (IDLE) → at cycle k+1: active_o=1, start=1, sync=1, subcycle=1, cnt=0.
- Subcycle strobes at k+1+n*(S+1). Sync strobes every (S+1)*(Y+1) cycles. S and Y are the shadow values.
- S=0: subcycle_o is high every RUN cycle.
- S=0 and Y=0: sync_o is high every RUN cycle.
- Burst of B periods: active_o is high for exactly B*(S+1)*(Y+1) cycles; done_o is high in the following cycle.
- en_i low at edge j → active_o=0 from cycle j+1.
- Counter arithmetic is unsigned. Wrap uses equality with the shadow value, never overflow.

## Structure
- Shared package wfg_core_pkg holds:
  - the state typedef (IDLE/RUN/HOLD);
  - mode constants MODE_CONT=0 and MODE_BURST=1.
- Sub-module wfg_core_timebase, parametrised by SUBW and SYNCW, implements sc/si, wrap flags and shadow reload.
- The top level holds the FSM, burst counter, channel comparators and output registers.

## Test plan
- S=3, Y=2, continuous, en held 40 cycles → subcycle strobe every 4 cycles, sync every 12, cnt sequence 0,1,2,0; start only once.
- Burst with S=1, Y=1, B=3 → active_o high for 12 cycles, done_o at cycle 13, then HOLD. Lowering en_i → IDLE. Raising it again → a fresh start.
- burst_len=0 with S=2, Y=0 → exactly 3 active cycles, then done_o.
- NCH=4, phases 0,1,2,7 with Y=3 → channels 0–2 strobe coincident with subcycle indices 0,1,2; channel 3 never fires.
- Change subcycle_cnt_i from 3 to 5 mid-period → current sync period keeps 4-cycle subcycles; next period uses 6.
- Mid-run en_i drop and, separately, wb_rst_i pulse → all outputs 0 the next cycle, no done_o. A burst whose end coincides with en_i low gives no done_o.

Source files
------------

// File: rtl/wfg_core_pkg.sv
// Shared types and constants for the waveform-generator core timing engine.
// Holds the run-state enumeration and the mode_i encodings.
package wfg_core_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } wfg_state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/wfg_core_timebase.sv
// Nested subcycle/sync counters with shadowed thresholds.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             load shadows from the inputs and zero sc/si (run entry)
//   adv_i               advance the counters by one clock (steady RUN)
//   sub_thr_i           subcycle threshold (subcycle = sub_thr_i+1 clocks)
//   sync_thr_i          sync threshold (sync period = sync_thr_i+1 subcycles)
//   sc_next_o/si_next_o counter values that take effect on the next edge
//   sub_wrap_o          sc is at its last clock of the subcycle
//   sync_wrap_o         sc and si are both at the last clock of the sync period
// With neither start_i nor adv_i asserted, the counters are held at zero.
module wfg_core_timebase #(
  parameter int unsigned SUBW  = 16,
  parameter int unsigned SYNCW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             adv_i,
  input  logic [SUBW-1:0]  sub_thr_i,
  input  logic [SYNCW-1:0] sync_thr_i,
  output logic [SUBW-1:0]  sc_next_o,
  output logic [SYNCW-1:0] si_next_o,
  output logic             sub_wrap_o,
  output logic             sync_wrap_o
);

  logic [SUBW-1:0]  sc_q, sc_d;
  logic [SYNCW-1:0] si_q, si_d;
  logic [SUBW-1:0]  sub_shadow_q, sub_shadow_d;
  logic [SYNCW-1:0] sync_shadow_q, sync_shadow_d;

  // Equality against the shadow, never overflow, defines the wrap points.
  assign sub_wrap_o  = (sc_q == sub_shadow_q);
  assign sync_wrap_o = sub_wrap_o && (si_q == sync_shadow_q);

  always_comb begin
    sc_d          = '0;
    si_d          = '0;
    sub_shadow_d  = sub_shadow_q;
    sync_shadow_d = sync_shadow_q;
    if (start_i) begin
      sub_shadow_d  = sub_thr_i;
      sync_shadow_d = sync_thr_i;
    end else if (adv_i) begin
      if (sub_wrap_o) begin
        if (sync_wrap_o) begin
          // Reconfiguration lands only here, so a period is never torn.
          sub_shadow_d  = sub_thr_i;
          sync_shadow_d = sync_thr_i;
        end else begin
          si_d = si_q + SYNCW'(1);
        end
      end else begin
        sc_d = sc_q + SUBW'(1);
        si_d = si_q;
      end
    end
  end

  assign sc_next_o = sc_d;
  assign si_next_o = si_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_q          <= '0;
      si_q          <= '0;
      sub_shadow_q  <= '0;
      sync_shadow_q <= '0;
    end else begin
      sc_q          <= sc_d;
      si_q          <= si_d;
      sub_shadow_q  <= sub_shadow_d;
      sync_shadow_q <= sync_shadow_d;
    end
  end

endmodule

// File: rtl/wfg_core_seq.sv
// Waveform-generator core timing engine: run FSM, burst counter, per-channel
// phase comparators and registered strobe outputs.
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   en_i, mode_i             run enable (level); 0 continuous / 1 burst
//   subcycle_cnt_i           subcycle length minus one
//   sync_cnt_i               sync period length in subcycles minus one
//   burst_len_i              sync periods per burst (0 behaves as 1)
//   ch_phase_i               per-channel subcycle index, SYNCW bits per channel
//   wfg_pat_*_o              sync/subcycle/start strobes and subcycle index
//   ch_strobe_o              per-channel phase strobes
//   done_o, active_o         burst-complete strobe, running indication
// All outputs are registered from next-state values so they line up with the
// cycle they describe.
module wfg_core_seq
  import wfg_core_pkg::*;
#(
  parameter int unsigned SUBW   = 16,
  parameter int unsigned SYNCW  = 8,
  parameter int unsigned BURSTW = 8,
  parameter int unsigned NCH    = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [SUBW-1:0]      subcycle_cnt_i,
  input  logic [SYNCW-1:0]     sync_cnt_i,
  input  logic [BURSTW-1:0]    burst_len_i,
  input  logic [NCH*SYNCW-1:0] ch_phase_i,
  output logic                 wfg_pat_sync_o,
  output logic                 wfg_pat_subcycle_o,
  output logic                 wfg_pat_start_o,
  output logic [SYNCW-1:0]     wfg_pat_subcycle_cnt_o,
  output logic [NCH-1:0]       ch_strobe_o,
  output logic                 done_o,
  output logic                 active_o
);

  wfg_state_e state_q, state_d;
  logic              mode_q, mode_d;
  logic [BURSTW-1:0] blen_q, blen_d;
  logic [BURSTW-1:0] bc_q, bc_d;
  logic [BURSTW-1:0] bc_last;

  logic             tb_start, tb_adv;
  logic [SUBW-1:0]  sc_next;
  logic [SYNCW-1:0] si_next;
  logic             sub_wrap, sync_wrap;

  logic             run_d, sub_start_d;
  logic             sync_d, subcycle_d, start_d, done_d;
  logic [SYNCW-1:0] cnt_d;
  logic [NCH-1:0]   ch_d;

  // Index of the final period of a burst; a zero length runs one period.
  assign bc_last = (blen_q == '0) ? '0 : blen_q - BURSTW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en_i) state_d = StRun;
      StRun: begin
        // en_i low wins over a coincident burst end: no done_o.
        if (!en_i) begin
          state_d = StIdle;
        end else if (sync_wrap && (mode_q == MODE_BURST) && (bc_q == bc_last)) begin
          state_d = StHold;
        end
      end
      StHold: if (!en_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign tb_start = (state_q == StIdle) && (state_d == StRun);
  assign tb_adv   = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    mode_d = mode_q;
    blen_d = blen_q;
    bc_d   = '0;
    if (tb_start) begin
      mode_d = mode_i;
      // Burst length is fixed for the whole burst.
      blen_d = burst_len_i;
    end else if (tb_adv) begin
      bc_d = bc_q;
      if (sync_wrap && (mode_q == MODE_BURST)) bc_d = bc_q + BURSTW'(1);
    end
  end

  wfg_core_timebase #(
    .SUBW (SUBW),
    .SYNCW(SYNCW)
  ) u_timebase (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .start_i    (tb_start),
    .adv_i      (tb_adv),
    .sub_thr_i  (subcycle_cnt_i),
    .sync_thr_i (sync_cnt_i),
    .sc_next_o  (sc_next),
    .si_next_o  (si_next),
    .sub_wrap_o (sub_wrap),
    .sync_wrap_o(sync_wrap)
  );

  always_comb begin
    run_d       = (state_d == StRun);
    sub_start_d = run_d && (sc_next == '0);
    subcycle_d  = sub_start_d;
    sync_d      = sub_start_d && (si_next == '0);
    start_d     = tb_start;
    done_d      = (state_q == StRun) && (state_d == StHold);
    cnt_d       = run_d ? si_next : '0;
    ch_d        = '0;
    // si never exceeds the current sync threshold, so an out-of-range phase stays silent.
    for (int c = 0; c < NCH; c++) begin
      ch_d[c] = sub_start_d && (si_next == ch_phase_i[c*SYNCW +: SYNCW]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q                <= StIdle;
      mode_q                 <= MODE_CONT;
      blen_q                 <= '0;
      bc_q                   <= '0;
      wfg_pat_sync_o         <= 1'b0;
      wfg_pat_subcycle_o     <= 1'b0;
      wfg_pat_start_o        <= 1'b0;
      wfg_pat_subcycle_cnt_o <= '0;
      ch_strobe_o            <= '0;
      done_o                 <= 1'b0;
      active_o               <= 1'b0;
    end else begin
      state_q                <= state_d;
      mode_q                 <= mode_d;
      blen_q                 <= blen_d;
      bc_q                   <= bc_d;
      wfg_pat_sync_o         <= sync_d;
      wfg_pat_subcycle_o     <= subcycle_d;
      wfg_pat_start_o        <= start_d;
      wfg_pat_subcycle_cnt_o <= cnt_d;
      ch_strobe_o            <= ch_d;
      done_o                 <= done_d;
      active_o               <= run_d;
    end
  end

endmodule

// File: tb/tb_wfg_core_seq.sv
// Self-checking bench for wfg_core_seq. Expected output vectors are pushed to
// a queue when stimulus is applied and popped/compared one per clock.
// Vector layout: {active, start, sync, subcycle, cnt[7:0], ch[3:0], done}.
module tb_wfg_core_seq;

  localparam int unsigned SUBW   = 16;
  localparam int unsigned SYNCW  = 8;
  localparam int unsigned BURSTW = 8;
  localparam int unsigned NCH    = 4;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 mode;
  logic [SUBW-1:0]      sub_cnt;
  logic [SYNCW-1:0]     sync_cnt;
  logic [BURSTW-1:0]    burst_len;
  logic [NCH*SYNCW-1:0] ch_phase;
  logic                 sync_o, subcycle_o, start_o, done_o, active_o;
  logic [SYNCW-1:0]     cnt_o;
  logic [NCH-1:0]       ch_o;

  int errors = 0;
  int checks = 0;
  int ph[NCH] = '{0, 1, 2, 7};
  logic [16:0] exp_q[$];

  wfg_core_seq #(
    .SUBW  (SUBW),
    .SYNCW (SYNCW),
    .BURSTW(BURSTW),
    .NCH   (NCH)
  ) dut (
    .wb_clk_i              (clk),
    .wb_rst_i              (rst),
    .en_i                  (en),
    .mode_i                (mode),
    .subcycle_cnt_i        (sub_cnt),
    .sync_cnt_i            (sync_cnt),
    .burst_len_i           (burst_len),
    .ch_phase_i            (ch_phase),
    .wfg_pat_sync_o        (sync_o),
    .wfg_pat_subcycle_o    (subcycle_o),
    .wfg_pat_start_o       (start_o),
    .wfg_pat_subcycle_cnt_o(cnt_o),
    .ch_strobe_o           (ch_o),
    .done_o                (done_o),
    .active_o              (active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector for run cycle n (0 = first RUN cycle) with fixed S and Y.
  function automatic logic [16:0] exp_run(int n, int s, int y, bit first);
    int          si;
    bit          sub;
    logic [3:0]  ch;
    logic [7:0]  cnt;
    sub = (n % (s + 1)) == 0;
    si  = (n / (s + 1)) % (y + 1);
    cnt = 8'(si);
    for (int c = 0; c < NCH; c++) ch[c] = sub && (si == ph[c]);
    return {1'b1, first && (n == 0), sub && (si == 0), sub, cnt, ch, 1'b0};
  endfunction

  task automatic push_run(int s, int y, int count, bit first);
    for (int n = 0; n < count; n++) exp_q.push_back(exp_run(n, s, y, first));
  endtask

  task automatic push_idle(int count);
    for (int n = 0; n < count; n++) exp_q.push_back(17'h0);
  endtask

  task automatic push_done();
    exp_q.push_back(17'h1);
  endtask

  // Pops one expected vector per clock and compares on the falling edge.
  task automatic drain(string name);
    logic [16:0] exp, obs;
    int          idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      obs = {active_o, start_o, sync_o, subcycle_o, cnt_o, ch_o, done_o};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: got act=%b st=%b sy=%b sub=%b cnt=%0d ch=%b dn=%b, want act=%b st=%b sy=%b sub=%b cnt=%0d ch=%b dn=%b",
                 name, idx, obs[16], obs[15], obs[14], obs[13], obs[12:5], obs[4:1], obs[0],
                 exp[16], exp[15], exp[14], exp[13], exp[12:5], exp[4:1], exp[0]);
      end
      idx++;
    end
  endtask

  task automatic set_cfg(int s, int y, int b, logic m);
    sub_cnt   = SUBW'(s);
    sync_cnt  = SYNCW'(y);
    burst_len = BURSTW'(b);
    mode      = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    push_idle(3);
    drain("reset");
    en = 1'b1;  // reset must override en
    push_idle(2);
    drain("reset_with_en");
    en  = 1'b0;
    rst = 1'b0;
    push_idle(2);
    drain("idle_after_reset");
  endtask

  task automatic test_continuous();
    set_cfg(3, 2, 0, 1'b0);
    en = 1'b1;
    push_run(3, 2, 40, 1'b1);
    drain("continuous");
    en = 1'b0;
    push_idle(2);
    drain("continuous_stop");
  endtask

  task automatic test_phases();
    set_cfg(0, 3, 0, 1'b0);
    en = 1'b1;
    push_run(0, 3, 16, 1'b1);
    drain("phases");
    en = 1'b0;
    push_idle(1);
    drain("phases_stop");
  endtask

  task automatic test_burst();
    set_cfg(1, 1, 3, 1'b1);
    en = 1'b1;
    push_run(1, 1, 12, 1'b1);
    push_done();
    push_idle(3);  // HOLD with en still high: no re-trigger
    drain("burst");
    en = 1'b0;
    push_idle(2);
    drain("burst_release");
    en = 1'b1;
    push_run(1, 1, 4, 1'b1);
    drain("burst_restart");
    en = 1'b0;
    push_idle(1);
    drain("burst_restart_stop");
  endtask

  task automatic test_burst_zero();
    set_cfg(2, 0, 0, 1'b1);
    en = 1'b1;
    push_run(2, 0, 3, 1'b1);
    push_done();
    push_idle(2);
    drain("burst_len0");
    en = 1'b0;
    push_idle(1);
    drain("burst_len0_stop");
  endtask

  task automatic test_reconfig();
    set_cfg(3, 1, 0, 1'b0);
    en = 1'b1;
    push_run(3, 1, 3, 1'b1);
    drain("reconfig_pre");
    sub_cnt = SUBW'(5);  // mid-period change must wait for the sync boundary
    for (int n = 3; n < 8; n++) exp_q.push_back(exp_run(n, 3, 1, 1'b0));
    push_run(5, 1, 12, 1'b0);
    drain("reconfig");
    en = 1'b0;
    push_idle(1);
    drain("reconfig_stop");
  endtask

  task automatic test_abort();
    set_cfg(3, 2, 0, 1'b0);
    en = 1'b1;
    push_run(3, 2, 5, 1'b1);
    drain("abort_pre");
    en = 1'b0;
    push_idle(2);
    drain("abort_en_drop");
    en = 1'b1;
    push_run(3, 2, 5, 1'b1);
    drain("rst_pre");
    rst = 1'b1;
    push_idle(1);
    drain("abort_rst");
    rst = 1'b0;
    push_run(3, 2, 2, 1'b1);
    drain("rst_restart");
    en = 1'b0;
    push_idle(1);
    drain("rst_restart_stop");
  endtask

  task automatic test_burst_coincide();
    set_cfg(1, 0, 2, 1'b1);
    en = 1'b1;
    push_run(1, 0, 4, 1'b1);
    drain("coincide_pre");
    en = 1'b0;  // sampled at the edge ending the final burst clock
    push_idle(3);
    drain("coincide_no_done");
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    ch_phase = {8'd7, 8'd2, 8'd1, 8'd0};
    set_cfg(0, 0, 0, 1'b0);
    test_reset();
    test_continuous();
    test_phases();
    test_burst();
    test_burst_zero();
    test_reconfig();
    test_abort();
    test_burst_coincide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
